// File: rtl/grid_access_ctl.sv
// rtl/grid_access_ctl.sv - read-modify-write sequencer/arbiter for the playboard grid RAM write port
// Optional build macro GRID_ACCESS_CTL_RR_EN: round-robin between shot and place requesters.
module grid_access_ctl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              place_req,
    input  logic [ADDR_W-1:0] place_addr,
    input  logic [1:0]        place_data,
    output logic              place_ack,
    output logic              place_err,
    input  logic              shot_req,
    input  logic [ADDR_W-1:0] shot_addr,
    output logic              shot_ack,
    output logic              shot_hit,
    output logic              shot_rep,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata,
    output logic [CNT_W-1:0]  ship_cells,
    output logic              all_sunk
);

    localparam logic [1:0] GRID_STATUS_EMPTY  = 2'd0;
    localparam logic [1:0] GRID_STATUS_MYSHIP = 2'd1;
    localparam logic [1:0] GRID_STATUS_MISS   = 2'd2;
    localparam logic [1:0] GRID_STATUS_HIT    = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_EVAL, S_WR, S_CLEAR} state_t;

    state_t     state, state_n;
    logic       clr_pend;
    logic       armed;
    logic       op_shot;
    logic [1:0] op_data;
    logic       grant_shot, grant_place;

    logic       ev_we, ev_err, ev_hit, ev_rep, ev_inc, ev_dec, ev_arm;
    logic [1:0] ev_wdata;

`ifdef GRID_ACCESS_CTL_RR_EN
    logic rr_ptr;

    always_comb begin
        grant_shot  = 1'b0;
        grant_place = 1'b0;
        if (shot_req && place_req) begin
            grant_shot  = !rr_ptr;
            grant_place = rr_ptr;
        end else begin
            grant_shot  = shot_req;
            grant_place = place_req;
        end
    end
`else
    always_comb begin
        grant_shot  = shot_req;
        grant_place = place_req && !shot_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (clr_pend)                   state_n = S_CLEAR;
                else if (shot_req || place_req) state_n = S_RD;
            end
            S_RD:    state_n = S_EVAL;
            S_EVAL:  state_n = S_WR;
            S_WR:    state_n = S_IDLE;
            S_CLEAR: if (mem_addr == '1) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Decide the write from the cell status returned for the latched address.
    always_comb begin
        ev_we    = 1'b0;
        ev_wdata = GRID_STATUS_EMPTY;
        ev_err   = 1'b0;
        ev_hit   = 1'b0;
        ev_rep   = 1'b0;
        ev_inc   = 1'b0;
        ev_dec   = 1'b0;
        ev_arm   = 1'b0;
        if (op_shot) begin
            case (mem_rdata)
                GRID_STATUS_MYSHIP: begin
                    ev_we = 1'b1; ev_wdata = GRID_STATUS_HIT; ev_hit = 1'b1; ev_dec = 1'b1;
                end
                GRID_STATUS_EMPTY: begin
                    ev_we = 1'b1; ev_wdata = GRID_STATUS_MISS;
                end
                default: ev_rep = 1'b1;
            endcase
        end else if (op_data == GRID_STATUS_MISS || op_data == GRID_STATUS_HIT ||
                     mem_rdata == GRID_STATUS_MISS || mem_rdata == GRID_STATUS_HIT) begin
            ev_err = 1'b1;
        end else if (op_data == GRID_STATUS_MYSHIP && mem_rdata == GRID_STATUS_EMPTY) begin
            ev_we = 1'b1; ev_wdata = GRID_STATUS_MYSHIP; ev_inc = 1'b1; ev_arm = 1'b1;
        end else if (op_data == GRID_STATUS_EMPTY && mem_rdata == GRID_STATUS_MYSHIP) begin
            ev_we = 1'b1; ev_wdata = GRID_STATUS_EMPTY; ev_dec = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_pend   <= 1'b0;
            armed      <= 1'b0;
            op_shot    <= 1'b0;
            op_data    <= 2'd0;
            place_ack  <= 1'b0;
            place_err  <= 1'b0;
            shot_ack   <= 1'b0;
            shot_hit   <= 1'b0;
            shot_rep   <= 1'b0;
            clear_done <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= 2'd0;
            ship_cells <= '0;
`ifdef GRID_ACCESS_CTL_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            place_ack  <= 1'b0;
            place_err  <= 1'b0;
            shot_ack   <= 1'b0;
            shot_hit   <= 1'b0;
            shot_rep   <= 1'b0;
            clear_done <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 2'd0;
            if (clear_req) clr_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (clr_pend) begin
                        if (!clear_req) clr_pend <= 1'b0;
                        mem_addr   <= '0;
                        mem_we     <= 1'b1;
                        mem_wdata  <= GRID_STATUS_EMPTY;
                        ship_cells <= '0;
                        armed      <= 1'b0;
                    end else if (grant_shot || grant_place) begin
                        op_shot  <= grant_shot;
                        op_data  <= place_data;
                        mem_addr <= grant_shot ? shot_addr : place_addr;
`ifdef GRID_ACCESS_CTL_RR_EN
                        rr_ptr   <= !rr_ptr;
`endif
                    end
                end
                S_EVAL: begin
                    mem_we     <= ev_we;
                    mem_wdata  <= ev_wdata;
                    shot_ack   <= op_shot;
                    shot_hit   <= ev_hit;
                    shot_rep   <= ev_rep;
                    place_ack  <= !op_shot;
                    place_err  <= ev_err;
                    ship_cells <= ship_cells + {{(CNT_W-1){1'b0}}, ev_inc}
                                             - {{(CNT_W-1){1'b0}}, ev_dec};
                    if (ev_arm) armed <= 1'b1;
                end
                S_CLEAR: begin
                    if (mem_addr == '1) begin
                        clear_done <= 1'b1;
                    end else begin
                        mem_addr  <= mem_addr + 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= GRID_STATUS_EMPTY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != S_IDLE) || clr_pend;
    assign all_sunk = armed && (ship_cells == '0);

endmodule

// File: tb/tb_grid_access_ctl.sv
// tb/tb_grid_access_ctl.sv - directed self-checking bench for grid_access_ctl
module tb_grid_access_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       place_req, shot_req, clear_req;
    logic [7:0] place_addr, shot_addr;
    logic [1:0] place_data;
    logic       place_ack, place_err, shot_ack, shot_hit, shot_rep, clear_done, busy;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;
    logic [8:0] ship_cells;
    logic       all_sunk;

    always #5 clk = ~clk;

    grid_access_ctl #(.ADDR_W(8), .CNT_W(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .place_req(place_req), .place_addr(place_addr), .place_data(place_data),
        .place_ack(place_ack), .place_err(place_err),
        .shot_req(shot_req), .shot_addr(shot_addr),
        .shot_ack(shot_ack), .shot_hit(shot_hit), .shot_rep(shot_rep),
        .clear_req(clear_req), .clear_done(clear_done), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ship_cells(ship_cells), .all_sunk(all_sunk)
    );

    // Grid RAM port model: one-cycle synchronous read, preloaded with mixed statuses.
    logic [1:0] ram [0:255];
    logic       preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 2'(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int         lat;
    logic       c_err, c_hit, c_rep, c_we, c_sunk;
    logic [1:0] c_wd;
    logic [7:0] c_addr;
    logic [8:0] c_ship;

    task automatic do_op(input bit is_shot, input logic [7:0] a, input logic [1:0] d);
        @(negedge clk);
        if (is_shot) begin
            shot_req = 1'b1; shot_addr = a;
        end else begin
            place_req = 1'b1; place_addr = a; place_data = d;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(is_shot ? shot_ack : place_ack) && lat < 12);
        c_err = place_err; c_hit = shot_hit; c_rep = shot_rep; c_we = mem_we;
        c_wd = mem_wdata; c_addr = mem_addr; c_ship = ship_cells; c_sunk = all_sunk;
        shot_req = 1'b0; place_req = 1'b0;
    endtask

    int         w, bad, acks, ts, tp, k;
    logic [5:0] seq;

    initial begin
        rst_n = 1'b0; place_req = 0; shot_req = 0; clear_req = 0;
        place_addr = 0; shot_addr = 0; place_data = 0;
        preload = 1'b1;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ship", ship_cells, 0);
        chk("rst_sunk", all_sunk, 0);
        chk("rst_acks", {place_ack, shot_ack, clear_done}, 0);
        chk("rst_addr", mem_addr, 0);

        // 1: bulk clear
        rst_n = 1'b1;
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("clr_busy", busy, 1);
        w = 0;
        while (!mem_we && w < 10) begin @(negedge clk); w++; end
        chk("clr_start", w, 1);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_addr !== 8'(i) || mem_we !== 1'b1 || mem_wdata !== 2'd0 || clear_done !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("clr_seq", bad, 0);
        chk("clr_done", clear_done, 1);
        chk("clr_we_off", mem_we, 0);
        chk("clr_ship", ship_cells, 0);
        chk("clr_idle", busy, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 2'd0) bad++;
        chk("clr_ram", bad, 0);
        @(negedge clk);
        chk("clr_done_pulse", clear_done, 0);

        // 2: place ship
        do_op(0, 8'h23, 2'd1);
        chk("p23_lat", lat, 3);
        chk("p23_err", c_err, 0);
        chk("p23_we", c_we, 1);
        chk("p23_addr", c_addr, 8'h23);
        chk("p23_wd", c_wd, 1);
        chk("p23_ship", c_ship, 1);
        chk("p23_sunk", c_sunk, 0);
        @(negedge clk);
        chk("p23_ack_pulse", place_ack, 0);
        chk("p23_ram", ram[8'h23], 1);

        // 3: hit it, then repeat
        do_op(1, 8'h23, 2'd0);
        chk("s23_lat", lat, 3);
        chk("s23_flags", {c_hit, c_rep}, 2'b10);
        chk("s23_we", {c_we, c_wd}, 3'b111);
        chk("s23_ship", c_ship, 0);
        chk("s23_sunk", c_sunk, 1);
        do_op(1, 8'h23, 2'd0);
        chk("s23r_flags", {c_hit, c_rep}, 2'b01);
        chk("s23r_we", c_we, 0);
        chk("s23r_ship", c_ship, 0);

        // 4: miss, then illegal placements, then put/remove
        do_op(1, 8'h00, 2'd0);
        chk("s00_flags", {c_hit, c_rep}, 2'b00);
        chk("s00_we", {c_we, c_wd}, 3'b110);
        do_op(0, 8'h00, 2'd1);
        chk("p00_err", c_err, 1);
        chk("p00_we", c_we, 0);
        do_op(0, 8'h10, 2'd2);
        chk("p10_err", c_err, 1);
        chk("p10_we", c_we, 0);
        do_op(0, 8'h45, 2'd1);
        chk("p45_ship", c_ship, 1);
        do_op(0, 8'h45, 2'd0);
        chk("r45_we", {c_we, c_wd, c_err}, 4'b1000);
        chk("r45_ship", c_ship, 0);

        // 5a: simultaneous requests, each dropped after its ack
        @(negedge clk);
        shot_req = 1; shot_addr = 8'h50;
        place_req = 1; place_addr = 8'h51; place_data = 2'd1;
        ts = 0; tp = 0;
        for (int t = 1; t <= 16 && (ts == 0 || tp == 0); t++) begin
            @(negedge clk);
            if (shot_ack)  begin ts = t; shot_req = 0; end
            if (place_ack) begin tp = t; place_req = 0; end
        end
        shot_req = 0; place_req = 0;
        chk("arb_shot_t", ts, 3);
        chk("arb_place_t", tp, 7);
        chk("arb_ship", ship_cells, 1);

        // 5b: both held continuously for three grants
        @(negedge clk);
        shot_req = 1; place_req = 1;
        seq = 0; k = 0; ts = 0;
        for (int t = 1; t <= 20 && k < 3; t++) begin
            @(negedge clk);
            if (shot_ack || place_ack) begin
                seq = {seq[3:0], place_ack, shot_ack};
                k++;
                ts = t;
            end
        end
        shot_req = 0; place_req = 0;
`ifdef GRID_ACCESS_CTL_RR_EN
        chk("rr_order", seq, 6'b01_10_01);
`else
        chk("fixed_order", seq, 6'b01_01_01);
`endif
        chk("held_third_t", ts, 11);
        chk("held_ship", ship_cells, 1);

        // 6a: clear arrives during shot EVAL
        @(negedge clk);
        shot_req = 1; shot_addr = 8'h51;
        @(negedge clk);
        @(negedge clk);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        chk("cev_ack", {shot_ack, shot_hit}, 2'b11);
        chk("cev_ship", ship_cells, 0);
        chk("cev_busy", busy, 1);
        shot_req = 0;
        @(negedge clk);
        chk("cev_idle_we", mem_we, 0);
        place_req = 1; place_addr = 8'h60; place_data = 2'd1;
        @(negedge clk);
        chk("cev_clr_first", {mem_we, mem_addr}, 9'h100);
        chk("cev_disarm", all_sunk, 0);
        w = 0; acks = 0;
        while (!clear_done && w < 300) begin
            @(negedge clk);
            w++;
            if (place_ack) acks++;
        end
        chk("cev_clr_len", w, 256);
        chk("cev_no_ack", acks, 0);
        w = 0;
        while (!place_ack && w < 12) begin @(negedge clk); w++; end
        place_req = 0;
        chk("cev_place_lat", w, 3);
        chk("cev_place_res", {place_err, ship_cells}, 10'd1);

        // 6b: reset during EVAL aborts the write
        @(negedge clk);
        shot_req = 1; shot_addr = 8'h23;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rev_we", mem_we, 0);
        chk("rev_ack", shot_ack, 0);
        chk("rev_outs", {busy, all_sunk, ship_cells, mem_addr, mem_wdata}, 0);
        rst_n = 1'b1; shot_req = 0;
        repeat (2) @(negedge clk);
        chk("rev_ram", ram[8'h23], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
